full_adder_32: RTL and testbench
================================

# full_adder_32

Registered 32-bit binary adder with carry-in and carry-out. It computes `{cout, sum} = a + b + cin` using a carry-lookahead structure and registers the result. Intended as a datapath arithmetic leaf; its post-route netlist must be bit-for-bit equivalent to the RTL at the output ports.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported; it must be a multiple of `GROUP`.
- `GROUP`, default 4: carry-lookahead group size in bits.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `a`, input, 32: addend A, unsigned.
- `b`, input, 32: addend B, unsigned.
- `cin`, input, 1: carry-in, weight 1.
- `sum`, output, 32: registered low 32 bits of `a + b + cin`.
- `cout`, output, 1: registered carry out of bit 31.

## Operation

- Arithmetic is unsigned modulo 2^33: `{cout, sum} = {1'b0,a} + {1'b0,b} + cin`. There is no overflow flag, and no signed interpretation is made.
- Per bit:
  - generate `g[i] = a[i] & b[i]`
  - propagate `p[i] = a[i] ^ b[i]`
  - `sum[i] = p[i] ^ c[i]`, with `c[0] = cin`.
- Each `GROUP`-bit block produces local carries by lookahead, plus group generate `G` and group propagate `P`.
- A second lookahead level across the 8 groups derives the group carry-ins. `cout` is the carry out of the top group.
- Results are combinational from the inputs and captured into the `sum`/`cout` registers each rising `clk` edge.
- There is no enable and no handshake. A new operand set may be presented every cycle.
- Every input value is legal. X/Z on inputs is not masked.

## Timing

- Latency is 1 cycle. Inputs stable before rising edge N produce `sum`/`cout` valid after edge N, held until edge N+1.
- Throughput is one addition per cycle.
- Reset values: while `rst_n`=0, `sum`=32'h0 and `cout`=0, applied immediately (asynchronously), not waiting for a clock edge.
- Reset release: the first capture happens on the first rising edge after `rst_n` goes high.
- Reset mid-stream: a pending result is discarded. Outputs read 0 until the first post-release edge, then show the operands present at that edge.
- The combinational path from any input to the register D pins must meet one `clk` period. The lookahead depth is O(log) in `WIDTH`; no ripple through all 32 bits is allowed.

## Structure

- Shared package `full_adder_pkg`:
  - `localparam int ADD_WIDTH = 32`
  - `localparam int CLA_GROUP = 4`
  - typedef `add_word_t` (logic [31:0])
- Sub-module `cla_group`:
  - inputs: `GROUP`-bit `a`, `GROUP`-bit `b`, `ci`
  - outputs: `s`, `G`, `P`
  - It is instantiated 8 times via generate.
- Top-level `full_adder_32` contains:
  - the group-level lookahead unit
  - the output register with async active-low clear
- No other state exists.

## Test plan

- **Reset:** assert `rst_n`=0 with `a`=32'hFFFFFFFF, `b`=1 → `sum`=0 and `cout`=0 immediately and throughout reset. Release reset, then one edge → `sum`=0, `cout`=1.
- **Zero:** `a`=0, `b`=0, `cin`=0 → after 1 edge, `sum`=0, `cout`=0.
- **Full carry chain:** `a`=32'hFFFFFFFF, `b`=0, `cin`=1 → `sum`=32'h00000000, `cout`=1.
- **Maximum:** `a`=32'hFFFFFFFF, `b`=32'hFFFFFFFF, `cin`=1 → `sum`=32'hFFFFFFFF, `cout`=1.
- **Group boundaries:**
  - `a`=32'h0000000F, `b`=1, `cin`=0 → `sum`=32'h00000010, `cout`=0.
  - `a`=32'h7FFFFFFF, `b`=1, `cin`=0 → `sum`=32'h80000000, `cout`=0.
- **Random regression:** change `a`, `b`, `cin` every cycle with 1000 random vectors. Compare against the model `{cout,sum}` = `a+b+cin` delayed one cycle. Run the same check on the post-route netlist with outputs matched per bit by name. Require zero mismatches.

Source files
------------

// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared widths and types for the registered carry-lookahead adder
//
// Contents:
//   ADD_WIDTH    operand width of the adder (32)
//   CLA_GROUP    bits per first-level lookahead group (4)
//   CLA_NGROUPS  number of first-level groups (8)
//   add_word_t   one 32-bit operand or result word

package full_adder_pkg;

    localparam int ADD_WIDTH   = 32;
    localparam int CLA_GROUP   = 4;
    localparam int CLA_NGROUPS = ADD_WIDTH / CLA_GROUP;

    typedef logic [ADD_WIDTH-1:0] add_word_t;

endpackage : full_adder_pkg

// File: rtl/full_adder_32_cla_group.sv
// rtl/full_adder_32_cla_group.sv - one GROUP-bit carry-lookahead block
//
// Ports:
//   a, b  in   GROUP-bit operand slices
//   ci    in   carry into bit 0 of the group
//   s     out  GROUP-bit sum slice
//   G     out  group generate (carry out assuming ci = 0)
//   P     out  group propagate (all bits propagate)

module cla_group
    import full_adder_pkg::*;
#(
    parameter int GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             G,
    output logic             P
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] c;
    logic             grp_g;
    logic             gterm;
    logic             cterm;

    assign g = a & b;
    assign p = a ^ b;

    // G and P are kept in their own process, independent of ci, so the
    // second-level lookahead in the parent can consume them without any
    // apparent path back from its own carry outputs.
    always_comb begin
        grp_g = 1'b0;
        gterm = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            gterm = g[j];
            for (int m = j + 1; m < GROUP; m++) begin
                gterm = gterm & p[m];
            end
            grp_g = grp_g | gterm;
        end
    end

    assign G = grp_g;
    assign P = &p;

    // Internal carries in flat sum-of-products form:
    //   c[i+1] = ci&p[0..i] | g[0]&p[1..i] | ... | g[i]
    // so every carry is two logic levels from g/p/ci, never a ripple.
    always_comb begin
        c     = '0;
        cterm = 1'b0;
        c[0]  = ci;
        for (int i = 0; i < GROUP - 1; i++) begin
            cterm = ci;
            for (int m = 0; m <= i; m++) begin
                cterm = cterm & p[m];
            end
            c[i+1] = cterm;
            for (int j = 0; j <= i; j++) begin
                cterm = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    cterm = cterm & p[m];
                end
                c[i+1] = c[i+1] | cterm;
            end
        end
    end

    assign s = p ^ c;

endmodule : cla_group

// File: rtl/full_adder_32.sv
// rtl/full_adder_32.sv - registered 32-bit two-level carry-lookahead adder
//
// Computes {cout, sum} = a + b + cin (unsigned, modulo 2^33) and registers it.
// Latency 1 cycle, one new operand set accepted every cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low clear of sum/cout
//   a, b   in   32-bit unsigned addends
//   cin    in   carry-in, weight 1
//   sum    out  registered low 32 bits of the result
//   cout   out  registered carry out of bit 31

module full_adder_32
    import full_adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NGROUPS = WIDTH / GROUP;

    if ((WIDTH != ADD_WIDTH) || ((WIDTH % GROUP) != 0)) begin : g_bad_param
        $error("full_adder_32: WIDTH must be 32 and a multiple of GROUP");
    end

    logic [NGROUPS-1:0] grp_g;
    logic [NGROUPS-1:0] grp_p;
    logic [NGROUPS:0]   gc;
    logic               gcterm;
    logic [WIDTH-1:0]   sum_d;
    logic               cout_d;

    // First level: one lookahead block per GROUP-bit slice.
    for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
        cla_group #(
            .GROUP (GROUP)
        ) u_cla_group (
            .a  (a[k*GROUP +: GROUP]),
            .b  (b[k*GROUP +: GROUP]),
            .ci (gc[k]),
            .s  (sum_d[k*GROUP +: GROUP]),
            .G  (grp_g[k]),
            .P  (grp_p[k])
        );
    end

    // Second level: group carry-ins from group G/P in flat sum-of-products
    // form, the same shape as inside a group, so the critical path is
    // bit g/p -> group G/P -> group carry -> in-group carry -> sum.
    always_comb begin
        gc     = '0;
        gcterm = 1'b0;
        gc[0]  = cin;
        for (int k = 0; k < NGROUPS; k++) begin
            gcterm = cin;
            for (int m = 0; m <= k; m++) begin
                gcterm = gcterm & grp_p[m];
            end
            gc[k+1] = gcterm;
            for (int j = 0; j <= k; j++) begin
                gcterm = grp_g[j];
                for (int m = j + 1; m <= k; m++) begin
                    gcterm = gcterm & grp_p[m];
                end
                gc[k+1] = gc[k+1] | gcterm;
            end
        end
    end

    assign cout_d = gc[NGROUPS];

    // Output register; the asynchronous clear also discards any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_d;
            cout <= cout_d;
        end
    end

endmodule : full_adder_32

// File: tb/tb_full_adder_32.sv
// tb/tb_full_adder_32.sv - self-checking bench for full_adder_32

module tb_full_adder_32;
    import full_adder_pkg::*;

    typedef struct {
        add_word_t a;
        add_word_t b;
        logic      cin;
        add_word_t exp_sum;
        logic      exp_cout;
    } vec_t;

    logic      clk;
    logic      rst_n;
    add_word_t a;
    add_word_t b;
    logic      cin;
    add_word_t sum;
    logic      cout;

    int tests_run;
    int tests_failed;

    full_adder_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input add_word_t exp_sum, input logic exp_cout);
        tests_run++;
        if (sum !== exp_sum || cout !== exp_cout) begin
            tests_failed++;
            $display("FAIL %s: got sum=%08h cout=%b, want sum=%08h cout=%b",
                     name, sum, cout, exp_sum, exp_cout);
        end
    endtask

    vec_t vecs[12];

    initial begin
        logic [32:0] model;
        logic [32:0] prev_model;
        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[3]  = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0};
        vecs[4]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
        vecs[5]  = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0};
        vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1};
        vecs[8]  = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1};
        vecs[9]  = '{32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 1'b0};
        vecs[10] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        vecs[11] = '{32'hDEADBEEF, 32'h21524110, 1'b1, 32'h00000000, 1'b1};

        // Async reset: drop rst_n between clock edges, outputs clear at once.
        rst_n = 1'b1;
        a     = 32'hFFFFFFFF;
        b     = 32'h00000001;
        cin   = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("reset_immediate", 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", 32'h0, 1'b0);
        end
        rst_n = 1'b1;
        #1 check("reset_release_before_edge", 32'h0, 1'b0);
        @(negedge clk);
        check("reset_first_capture", 32'h00000000, 1'b1);

        // Directed table: apply on the falling edge, check one edge later.
        for (int i = 0; i < 12; i++) begin
            a   = vecs[i].a;
            b   = vecs[i].b;
            cin = vecs[i].cin;
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Reset mid-stream: the captured result is discarded and operands
        // presented during reset are never captured.
        a = 32'h00000005; b = 32'h00000006; cin = 1'b0;
        @(posedge clk);
        #1 check("midreset_before", 32'h0000000B, 1'b0);
        #1 rst_n = 1'b0;
        #1 check("midreset_clear", 32'h0, 1'b0);
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1;
        @(negedge clk);
        check("midreset_hold", 32'h0, 1'b0);
        rst_n = 1'b1;
        a = 32'h00000100; b = 32'h00000200; cin = 1'b1;
        #1 check("midreset_release", 32'h0, 1'b0);
        @(negedge clk);
        check("midreset_first_capture", 32'h00000301, 1'b0);

        // Back-to-back random operands, one per cycle, against a plain
        // 33-bit addition delayed by one cycle.
        prev_model = '0;
        for (int i = 0; i <= 1000; i++) begin
            if (i > 0) begin
                check($sformatf("rand%0d", i - 1), prev_model[31:0], prev_model[32]);
            end
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            model      = {1'b0, a} + {1'b0, b} + {32'h0, cin};
            prev_model = model;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_full_adder_32
